// File: rtl/apb_busint_n.sv
// apb_busint_n: parametrised APB slave front-end.
// Decodes Paddr select bits to NUM_CH channel enables with wait-state insertion.
module apb_busint_n #(
  parameter int NUM_CH      = 3,
  parameter int SEL_W       = 2,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                     i_Pclk,
  input  logic                     i_Preset,
  input  logic [31:0]              i_Paddr,
  input  logic                     i_Psel,
  input  logic                     i_Penable,
  input  logic                     i_Pwrite,
  input  logic [DATA_W-1:0]        i_Pwdata,
  input  logic [NUM_CH*DATA_W-1:0] i_Ch_Rdata,
  output logic [DATA_W-1:0]        o_Prdata,
  output logic                     o_Pready,
  output logic                     o_Pslverr,
  output logic [NUM_CH-1:0]        o_Ch_En,
  output logic                     o_Ch_Wr,
  output logic [DATA_W-1:0]        o_Wdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t              st_q, st_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;

  logic [DATA_W-1:0]   prdata_d;
  logic                pready_d;
  logic                pslverr_d;
  logic [NUM_CH-1:0]   ch_en_d;
  logic                ch_wr_d;
  logic [DATA_W-1:0]   wdata_d;

  logic [SEL_W-1:0]    cur_idx;
  logic                cur_wr;
  logic [DATA_W-1:0]   cur_wd;
  logic [DATA_W-1:0]   cur_rd;
  logic [NUM_CH-1:0]   cur_en;
  logic                cur_map;
  logic                fin;

  logic                unused_addr;
  assign unused_addr = ^i_Paddr[31-SEL_W:0];

  // In IDLE the transfer is described by the bus; afterwards by the latches.
  assign cur_idx = (st_q == IDLE) ? i_Paddr[31 -: SEL_W] : idx_q;
  assign cur_wr  = (st_q == IDLE) ? i_Pwrite : wr_q;
  assign cur_wd  = (st_q == IDLE) ? i_Pwdata : wd_q;

  always_comb begin
    cur_rd = '0;
    cur_en = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_idx == SEL_W'(k)) begin
        cur_rd    = i_Ch_Rdata[k*DATA_W +: DATA_W];
        cur_en[k] = 1'b1;
      end
    end
  end

  assign cur_map = |cur_en;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wd_d      = wd_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    ch_en_d   = '0;
    ch_wr_d   = 1'b0;
    wdata_d   = o_Wdata;
    fin       = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (i_Psel && !i_Penable) begin
          st_d    = ACCESS;
          cnt_d   = '0;
          idx_d   = cur_idx;
          wr_d    = i_Pwrite;
          wd_d    = i_Pwdata;
          ch_en_d = cur_en;
          fin     = !cur_map || (WS == 4'd0);
        end
      end
      ACCESS: begin
        // Completion or abort both end the transfer; a SETUP here is dropped.
        if (o_Pready || !i_Psel) begin
          st_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          ch_en_d = cur_en;
          fin     = (cnt_d == WS);
        end
      end
    endcase
    if (fin) begin
      pready_d  = 1'b1;
      pslverr_d = !cur_map;
      if (cur_map && !cur_wr) prdata_d = cur_rd;
      if (cur_map && cur_wr) begin
        ch_wr_d = 1'b1;
        wdata_d = cur_wd;
      end
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
      o_Prdata  <= '0;
      o_Pready  <= 1'b0;
      o_Pslverr <= 1'b0;
      o_Ch_En   <= '0;
      o_Ch_Wr   <= 1'b0;
      o_Wdata   <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wd_q      <= wd_d;
      o_Prdata  <= prdata_d;
      o_Pready  <= pready_d;
      o_Pslverr <= pslverr_d;
      o_Ch_En   <= ch_en_d;
      o_Ch_Wr   <= ch_wr_d;
      o_Wdata   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_apb_busint_n.sv
// tb_apb_busint_n: scoreboard bench driving two apb_busint_n builds
// (0 and 2 wait states) from one APB master.
module tb_apb_busint_n;

  localparam int WS1 = 2;

  typedef struct {
    int          done;
    logic [31:0] rd;
    logic        err;
    logic        wr;
    logic [31:0] wd;
    logic [2:0]  en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [95:0] ch_rdata;

  logic [31:0] prdata0, wdata0, prdata1, wdata1;
  logic        pready0, pslverr0, chwr0;
  logic        pready1, pslverr1, chwr1;
  logic [2:0]  en0, en1;

  logic [31:0] chv [3];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_busint_n #(.NUM_CH(3), .SEL_W(2), .DATA_W(32), .WAIT_STATES(0)) u0 (
    .i_Pclk(clk), .i_Preset(rst), .i_Paddr(paddr), .i_Psel(psel),
    .i_Penable(penable), .i_Pwrite(pwrite), .i_Pwdata(pwdata),
    .i_Ch_Rdata(ch_rdata), .o_Prdata(prdata0), .o_Pready(pready0),
    .o_Pslverr(pslverr0), .o_Ch_En(en0), .o_Ch_Wr(chwr0), .o_Wdata(wdata0)
  );

  apb_busint_n #(.NUM_CH(3), .SEL_W(2), .DATA_W(32), .WAIT_STATES(WS1)) u1 (
    .i_Pclk(clk), .i_Preset(rst), .i_Paddr(paddr), .i_Psel(psel),
    .i_Penable(penable), .i_Pwrite(pwrite), .i_Pwdata(pwdata),
    .i_Ch_Rdata(ch_rdata), .o_Prdata(prdata1), .o_Pready(pready1),
    .o_Pslverr(pslverr1), .o_Ch_En(en1), .o_Ch_Wr(chwr1), .o_Wdata(wdata1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int u, input logic rdy, input logic err,
                     input logic [31:0] rd, input logic [2:0] en,
                     input logic wr, input logic [31:0] wd);
    exp_t e;
    chk($sformatf("u%0d_onehot0", u), 32'($onehot0(en)), 32'd1);
    if (!rdy) begin
      chk($sformatf("u%0d_idle_prdata", u), rd, 32'd0);
      chk($sformatf("u%0d_idle_err_wr", u), {30'd0, err, wr}, 32'd0);
    end else if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL u%0d_unexpected_pready: got 1 expected 0 at cycle %0d",
               u, cyc);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("u%0d_latency", u), 32'(cyc), 32'(e.done));
      chk($sformatf("u%0d_prdata", u), rd, e.rd);
      chk($sformatf("u%0d_pslverr", u), {31'd0, err}, {31'd0, e.err});
      chk($sformatf("u%0d_ch_wr", u), {31'd0, wr}, {31'd0, e.wr});
      chk($sformatf("u%0d_ch_en", u), {29'd0, en}, {29'd0, e.en});
      if (e.wr) chk($sformatf("u%0d_wdata", u), wd, e.wd);
    end
  endtask

  always @(negedge clk) begin
    mon(0, pready0, pslverr0, prdata0, en0, chwr0, wdata0);
    mon(1, pready1, pslverr1, prdata1, en1, chwr1, wdata1);
  end

  task automatic all_zero(input string name);
    chk({name, "_u0_ctl"}, {26'd0, pready0, pslverr0, chwr0, en0}, 32'd0);
    chk({name, "_u0_data"}, prdata0 | wdata0, 32'd0);
    chk({name, "_u1_ctl"}, {26'd0, pready1, pslverr1, chwr1, en1}, 32'd0);
    chk({name, "_u1_data"}, prdata1 | wdata1, 32'd0);
  endtask

  // One APB transfer; abort_k >= 0 drops Psel after abort_k extra cycles.
  task automatic xfer(input logic [1:0] idx, input logic wr,
                      input logic [31:0] wd, input int abort_k,
                      input bit rnd, input int gap);
    exp_t e;
    int   lat1;
    bit   mapped;
    mapped = (idx < 2'd3);
    if (rnd) for (int k = 0; k < 3; k++) chv[k] = $urandom;
    ch_rdata = {chv[2], chv[1], chv[0]};
    lat1   = mapped ? WS1 + 1 : 1;
    e.rd   = (mapped && !wr) ? chv[idx] : 32'd0;
    e.err  = !mapped;
    e.wr   = mapped && wr;
    e.wd   = wd;
    e.en   = mapped ? 3'(1 << idx) : 3'd0;
    e.done = cyc + 1;
    q0.push_back(e);
    if (abort_k < 0) begin
      e.done = cyc + lat1;
      q1.push_back(e);
    end
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = {idx, 30'($urandom)};
    pwrite  = wr;
    pwdata  = wd;
    @(posedge clk) #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = $urandom;
    repeat (abort_k < 0 ? lat1 : abort_k) @(posedge clk) #1;
    psel    = 1'b0;
    penable = 1'b0;
    if (abort_k >= 0) begin
      @(posedge clk) #1;
      chk("abort_en_clear", {29'd0, en1}, 32'd0);
      chk("abort_no_ready", {30'd0, pready1, chwr1}, 32'd0);
    end
    repeat (gap) @(posedge clk) #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] wd;
    rst      = 1'b1;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    chv[0]   = 32'hA5A5_0001;
    chv[1]   = 32'h1111_2222;
    chv[2]   = 32'h3333_4444;
    ch_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk) #1;

    xfer(2'd0, 1'b0, $urandom, -1, 1'b0, 1);
    xfer(2'd1, 1'b1, 32'h0000_00C3, -1, 1'b1, 1);
    xfer(2'd3, 1'b0, $urandom, -1, 1'b1, 1);
    xfer(2'd2, 1'b1, $urandom, 1, 1'b1, 1);

    // Reset in the middle of a wait-stated ch1 write.
    wd = 32'hDEAD_0C01;
    begin
      exp_t e;
      e.done = cyc + 1;
      e.rd   = 32'd0;
      e.err  = 1'b0;
      e.wr   = 1'b1;
      e.wd   = wd;
      e.en   = 3'b010;
      q0.push_back(e);
    end
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = {2'b01, 30'h123};
    pwrite  = 1'b1;
    pwdata  = wd;
    @(posedge clk) #1;
    penable = 1'b1;
    @(posedge clk) #1;
    chk("rst_pre_en", {29'd0, en1}, 32'h2);
    #2 rst = 1'b1;
    #1 all_zero("rst_async");
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;
    xfer(2'd0, 1'b0, $urandom, -1, 1'b1, 1);

    xfer(2'd0, 1'b0, $urandom, -1, 1'b1, 1);
    xfer(2'd1, 1'b1, $urandom, -1, 1'b1, 1);
    xfer(2'd2, 1'b0, $urandom, -1, 1'b1, 1);
    xfer(2'd3, 1'b0, $urandom, -1, 1'b1, 1);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] idx;
      int         ab;
      idx = 2'($urandom_range(0, 3));
      ab  = -1;
      if (idx != 2'd3 && $urandom_range(0, 4) == 0)
        ab = $urandom_range(0, WS1 - 1);
      xfer(idx, 1'($urandom), $urandom, ab, 1'b1, $urandom_range(1, 3));
    end

    repeat (4) @(posedge clk) #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
